uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter: the frame state
// encoding and the oversampling / frame-length constants.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int START_SAMPLE = 8;
  localparam int DATA_BITS    = 8;

  // Tick-count values at which the FSM acts: the last tick of a full bit
  // period, the mid-point of the start bit, and the index of the final data bit.
  localparam logic [3:0] TICK_LAST       = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] START_TICK_LAST = 4'(START_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST        = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick prescaler. Counts 0..BAUD_DIV-1 and raises tick for one
// clock while the count equals BAUD_DIV-1. A synchronous clear restarts the
// count so the first tick after clr lands BAUD_DIV clocks later.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   clr   in   synchronous restart of the prescaler
//   tick  out  one-cycle oversample tick
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int BAUD_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

  logic [15:0] count;

  // The tick is decoded straight from the count so it lines up with the
  // clock on which the count wraps back to zero.
  always_comb begin
    tick = (count == DIV_LAST);
  end

  // Free-running prescaler; reset and clr both restart it from zero, and it
  // wraps on the tick so the period is exactly BAUD_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, 16x oversampling with mid-bit sampling.
// Received bytes are presented on a valid/ready holding register; framing
// and overrun errors are reported as one-cycle pulses.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   rx          in   asynchronous serial input, idle high
//   data        out  received byte, stable while data_valid=1
//   data_valid  out  byte available, held until accepted
//   data_ready  in   consumer accepts when data_valid & data_ready
//   frame_err   out  one-cycle pulse: stop bit sampled 0
//   overrun     out  one-cycle pulse: new byte dropped, register full
// ---------------------------------------------------------------------------
import uart_pkg::*;

module uart_rx #(
  parameter int BAUD_DIV = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  uart_state_t state;
  uart_state_t state_next;

  logic       rx_meta;
  logic       rx_s;
  logic       rx_q;
  logic       tick;
  logic       clr_presc;
  logic       clr_ticks;
  logic       load_bit;
  logic       stop_sample;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       frame_done;
  logic       stop_bit;
  logic       deliver;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr_presc),
    .tick(tick)
  );

  // State register. Reset always lands in IDLE, abandoning any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. Only a genuine high-to-low transition
  // starts a frame, so a line stuck low (break) is ignored. The start bit is
  // re-checked at its midpoint to reject glitches; every later bit is taken
  // one full bit period (16 ticks) after the previous sample. After the stop
  // sample the FSM goes straight back to IDLE so the next start edge can be
  // caught during the remainder of the stop bit.
  always_comb begin
    state_next  = state;
    clr_presc   = 1'b0;
    clr_ticks   = 1'b0;
    load_bit    = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (rx_q && !rx_s) begin
          clr_presc  = 1'b1;
          clr_ticks  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (tick && (tick_cnt == START_TICK_LAST)) begin
          if (!rx_s) begin
            clr_ticks  = 1'b1;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && (tick_cnt == TICK_LAST)) begin
          load_bit = 1'b1;
          if (bit_idx == BIT_LAST) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick && (tick_cnt == TICK_LAST)) begin
          stop_sample = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Input synchronizer, edge-detect history, tick/bit counters and the
  // shift register. The stop sample is captured into frame_done/stop_bit so
  // the holding-register update happens on the following clock. The 4-bit
  // tick counter wraps naturally at 16, which keeps the data and stop
  // samples one bit period apart without an explicit clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      frame_done <= 1'b0;
      stop_bit   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
      if (clr_ticks) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      if (clr_ticks) begin
        bit_idx <= '0;
      end else if (load_bit) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (load_bit) begin
        shift[bit_idx] <= rx_s;
      end
      frame_done <= stop_sample;
      if (stop_sample) begin
        stop_bit <= rx_s;
      end
    end
  end

  always_comb begin
    deliver = frame_done && stop_bit;
  end

  // Holding register and error pulses. A delivery into a full register is
  // still accepted when the consumer takes the old byte in that same cycle;
  // otherwise the new byte is dropped and overrun pulses. A bad stop bit
  // discards the byte without touching data_valid. Both error pulses come
  // from the single frame_done event, so they can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_done && !stop_bit;
      overrun   <= 1'b0;
      if (deliver && (!data_valid || data_ready)) begin
        data       <= shift;
        data_valid <= 1'b1;
      end else if (deliver) begin
        overrun <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with BAUD_DIV=4 (64 clocks per bit). Serial
// frames are driven one clock at a time from the main process, which also
// plays the consumer side of the valid/ready handshake.
// ---------------------------------------------------------------------------
import uart_pkg::*;

module tb_uart_rx;

  localparam int BIT_CLKS = 64;
  // rx is driven just after a clock; two synchronizer stages plus the
  // detect register put edge detection 3 clocks later, and delivery lands
  // 152*4+1 clocks after detection.
  localparam int DELIVERY_LAT = 3 + 152 * 4 + 1;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  int total;
  int bad;
  int cyc;
  int dropCyc;
  int dvRiseCyc;
  int dvRises;
  int dvFalls;
  int feHigh;
  int ovHigh;
  int bothHigh;
  logic dvPrev;
  logic [7:0] rxQ[$];
  int snapFalls;
  int snapFe;
  int snapOv;
  int snapRises;

  uart_rx #(
    .BAUD_DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and output monitor, sampled 1 time unit after each edge.
  initial begin
    cyc = 0; dvRises = 0; dvFalls = 0; feHigh = 0; ovHigh = 0;
    bothHigh = 0; dvRiseCyc = 0; dvPrev = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (frame_err === 1'b1) feHigh++;
      if (overrun === 1'b1) ovHigh++;
      if ((frame_err === 1'b1) && (overrun === 1'b1)) bothHigh++;
      if ((data_valid === 1'b1) && !dvPrev) begin
        dvRises++;
        dvRiseCyc = cyc;
      end
      if ((data_valid === 1'b0) && dvPrev) dvFalls++;
      dvPrev = (data_valid === 1'b1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus. ackMode 0: never ready; 1: pulse ready for one
  // cycle after each valid; 2: ready only in the expected delivery cycle.
  task automatic applyStimulus(input logic rxBit, input int ackMode);
    rx = rxBit;
    if (ackMode == 1) begin
      if (data_ready) begin
        data_ready = 1'b0;
      end else if (data_valid) begin
        rxQ.push_back(data);
        data_ready = 1'b1;
      end
    end else if (ackMode == 2) begin
      data_ready = (cyc == dropCyc + DELIVERY_LAT - 1);
    end else begin
      data_ready = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int ackMode);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, ackMode);
  endtask

  // Full 8N1 frame. abortSlot >= 0 pulses rst mid-way through that bit slot
  // (slot 0 = start bit, 1..8 = data bits 0..7) and returns the line high.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                           input int ackMode, input int abortSlot);
    logic bitVal;
    dropCyc = cyc;
    for (int slot = 0; slot < 10; slot++) begin
      if (slot == 0) bitVal = 1'b0;
      else if (slot == 9) bitVal = stopBit;
      else bitVal = b[3'(slot - 1)];
      for (int k = 0; k < BIT_CLKS; k++) begin
        if ((slot == abortSlot) && (k == BIT_CLKS / 2)) begin
          rx = 1'b1;
          data_ready = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        applyStimulus(bitVal, ackMode);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", 32'(data), 32'h0);
    checkOutput("rst_valid", 32'(data_valid), 32'h0);
    checkOutput("rst_ferr", 32'(frame_err), 32'h0);
    checkOutput("rst_ovr", 32'(overrun), 32'h0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    idle(10, 0);

    $display("[TB] scenario 1: single byte 0xA5");
    sendFrame(8'hA5, 1'b1, 0, -1);
    idle(10, 0);
    checkOutput("t1_latency", 32'(dvRiseCyc - dropCyc), 32'(DELIVERY_LAT));
    checkOutput("t1_data", 32'(data), 32'hA5);
    checkOutput("t1_valid", 32'(data_valid), 32'h1);
    checkOutput("t1_ferr", 32'(feHigh), 32'h0);
    checkOutput("t1_ovr", 32'(ovHigh), 32'h0);
    idle(4, 1);
    checkOutput("t1_consumed", 32'(data_valid), 32'h0);
    checkOutput("t1_data_hold", 32'(data), 32'hA5);

    $display("[TB] scenario 2: back-to-back 0x00, 0xFF");
    rxQ.delete();
    sendFrame(8'h00, 1'b1, 1, -1);
    sendFrame(8'hFF, 1'b1, 1, -1);
    idle(20, 1);
    checkOutput("t2_count", 32'(rxQ.size()), 32'd2);
    if (rxQ.size() >= 2) begin
      checkOutput("t2_byte0", 32'(rxQ[0]), 32'h00);
      checkOutput("t2_byte1", 32'(rxQ[1]), 32'hFF);
    end
    checkOutput("t2_ferr", 32'(feHigh), 32'h0);
    checkOutput("t2_ovr", 32'(ovHigh), 32'h0);
    checkOutput("t2_valid", 32'(data_valid), 32'h0);

    $display("[TB] scenario 3: 20-clock glitch");
    snapRises = dvRises;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0);
    checkOutput("t3_state_start", 32'(dut.state), 32'(START));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0);
    idle(60, 0);
    checkOutput("t3_state_idle", 32'(dut.state), 32'(IDLE));
    checkOutput("t3_no_valid", 32'(dvRises - snapRises), 32'h0);
    checkOutput("t3_ferr", 32'(feHigh), 32'h0);

    $display("[TB] scenario 4: framing error then good frame");
    sendFrame(8'h3C, 1'b0, 0, -1);
    idle(BIT_CLKS, 0);
    checkOutput("t4_ferr_pulse", 32'(feHigh), 32'd1);
    checkOutput("t4_valid_low", 32'(data_valid), 32'h0);
    sendFrame(8'h3C, 1'b1, 0, -1);
    idle(10, 0);
    checkOutput("t4_data", 32'(data), 32'h3C);
    checkOutput("t4_valid", 32'(data_valid), 32'h1);
    checkOutput("t4_ferr_once", 32'(feHigh), 32'd1);
    idle(4, 1);

    $display("[TB] scenario 5: overrun and same-cycle accept");
    sendFrame(8'h11, 1'b1, 0, -1);
    sendFrame(8'h22, 1'b1, 0, -1);
    idle(10, 0);
    checkOutput("t5_data_kept", 32'(data), 32'h11);
    checkOutput("t5_valid", 32'(data_valid), 32'h1);
    checkOutput("t5_ovr_pulse", 32'(ovHigh), 32'd1);
    snapFalls = dvFalls;
    sendFrame(8'h22, 1'b1, 2, -1);
    idle(10, 0);
    checkOutput("t5_data_new", 32'(data), 32'h22);
    checkOutput("t5_valid_held", 32'(dvFalls - snapFalls), 32'h0);
    checkOutput("t5_no_ovr", 32'(ovHigh), 32'd1);
    checkOutput("t5_exclusive", 32'(bothHigh), 32'h0);

    $display("[TB] scenario 6: reset mid-frame");
    snapFe = feHigh;
    snapOv = ovHigh;
    snapRises = dvRises;
    sendFrame(8'hA5, 1'b1, 0, 5);
    checkOutput("t6_data", 32'(data), 32'h0);
    checkOutput("t6_valid", 32'(data_valid), 32'h0);
    checkOutput("t6_state", 32'(dut.state), 32'(IDLE));
    idle(100, 0);
    checkOutput("t6_no_err", 32'((feHigh - snapFe) + (ovHigh - snapOv)), 32'h0);
    checkOutput("t6_no_delivery", 32'(dvRises - snapRises), 32'h0);
    sendFrame(8'h5A, 1'b1, 0, -1);
    idle(10, 0);
    checkOutput("t6_data_after", 32'(data), 32'h5A);
    checkOutput("t6_valid_after", 32'(data_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
